// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: data width, NOP encoding,
// instruction-fetch FSM state encoding and PC arithmetic helpers.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] step);
    return pc + step;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_if_skid.sv
// One-entry {inst, npc} skid register: parks a fetched instruction while the
// decode stage is stalled. Clear has priority over load.
module mips_if_skid
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] d_inst,
  input  logic [XLEN-1:0] d_npc,
  output logic            valid,
  output logic [XLEN-1:0] q_inst,
  output logic [XLEN-1:0] q_npc
);

  // Skid entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      q_inst <= MIPS_NOP;
      q_npc  <= 32'h0000_0000;
    end else if (clear) begin
      valid  <= 1'b0;
      q_inst <= MIPS_NOP;
      q_npc  <= 32'h0000_0000;
    end else if (load) begin
      valid  <= 1'b1;
      q_inst <= d_inst;
      q_npc  <= d_npc;
    end else begin
      valid  <= valid;
      q_inst <= q_inst;
      q_npc  <= q_npc;
    end
  end

endmodule

// File: rtl/mips_if_stage.sv
// MIPS instruction-fetch stage: PC, request-held imem handshake, IF/ID output
// registers, stall skid and EX redirect. Optional counters: MIPS_IF_PERF_CNT_EN.
module mips_if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] inst,
`ifdef MIPS_IF_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic        inst_valid
`else
  output logic        inst_valid
`endif
);

  if_state_e   state_r;
  logic [31:0] pc_inc_s;
  logic        accept_s;
  logic        skid_load_s;
  logic        skid_clear_s;
  logic        skid_valid_s;
  logic [31:0] skid_inst_s;
  logic [31:0] skid_npc_s;

  // Skid control decode
  always_comb begin
    pc_inc_s     = pc_add(pc, PC_STEP);
    accept_s     = (state_r == IF_REQ) && imem_rvalid && !redirect;
    skid_load_s  = accept_s && stall;
    skid_clear_s = redirect || ((state_r == IF_HOLD) && !stall);
  end

  mips_if_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load_s),
    .clear  (skid_clear_s),
    .d_inst (imem_rdata),
    .d_npc  (pc_inc_s),
    .valid  (skid_valid_s),
    .q_inst (skid_inst_s),
    .q_npc  (skid_npc_s)
  );

  assign imem_addr = pc;

  // Fetch FSM with registered PC, request and IF/ID outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IF_IDLE;
      imem_req   <= 1'b0;
      pc         <= RESET_PC;
      npc        <= 32'h0000_0000;
      inst       <= MIPS_NOP;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      state_r    <= IF_REQ;
      imem_req   <= 1'b1;
      pc         <= word_align(redirect_pc);
      inst       <= MIPS_NOP;
      inst_valid <= 1'b0;
    end else begin
      case (state_r)
        IF_IDLE: begin
          state_r  <= IF_REQ;
          imem_req <= 1'b1;
        end
        IF_REQ: begin
          if (stall) begin
            // Stalled fetch completing: park it in the skid and stop requesting
            if (imem_rvalid) begin
              pc       <= pc_inc_s;
              state_r  <= IF_HOLD;
              imem_req <= 1'b0;
            end
          end else if (imem_rvalid) begin
            inst       <= imem_rdata;
            npc        <= pc_inc_s;
            inst_valid <= 1'b1;
            pc         <= pc_inc_s;
          end else begin
            inst       <= MIPS_NOP;
            inst_valid <= 1'b0;
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            inst       <= skid_inst_s;
            npc        <= skid_npc_s;
            inst_valid <= skid_valid_s;
            state_r    <= IF_REQ;
            imem_req   <= 1'b1;
          end
        end
        default: begin
          state_r  <= IF_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIPS_IF_PERF_CNT_EN
  // Fetch and stall event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'h0000_0000;
      stall_cnt <= 32'h0000_0000;
    end else begin
      fetch_cnt <= accept_s ? fetch_cnt + 32'd1 : fetch_cnt;
      stall_cnt <= (stall && !redirect) ? stall_cnt + 32'd1 : stall_cnt;
    end
  end
`endif

endmodule
